// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed seven-segment driver.
// Segment codes are stored active-high, bit 6 = g down to bit 0 = a.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF_H = 7'b0000000;

  // Index is the hex value; leftmost entry is F.
  localparam logic [15:0][6:0] SEG_TABLE_H = {
    7'b1110001, 7'b1111001, 7'b1011110, 7'b0111001,
    7'b1111100, 7'b1110111, 7'b1101111, 7'b1111111,
    7'b0000111, 7'b1111101, 7'b1101101, 7'b1100110,
    7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111
  };

  function automatic logic [6:0] seg_polarity(input logic [6:0] seg_h, input bit active_low);
    return active_low ? ~seg_h : seg_h;
  endfunction

endpackage

// File: rtl/seg7_mux_display_if.sv
// Datapath-side bundle of the seven-segment driver: digit data in, pin drives out.
interface seg7_mux_display_if #(
  parameter int unsigned N_DIGITS = 4
);

  logic [4*N_DIGITS-1:0] digits;
  logic [N_DIGITS-1:0]   dp_in;
  logic [N_DIGITS-1:0]   blank_in;
  logic                  load;
  logic                  lz_en;
  logic [6:0]            D;
  logic                  Dp;
  logic [N_DIGITS-1:0]   An;
  logic                  frame_done;

  modport master (
    output digits, dp_in, blank_in, load, lz_en,
    input  D, Dp, An, frame_done
  );

  modport slave (
    input  digits, dp_in, blank_in, load, lz_en,
    output D, Dp, An, frame_done
  );

endinterface

// File: rtl/hex_to_7seg.sv
// Combinational hex digit to seven-segment decoder with selectable polarity.
module hex_to_7seg #(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);
  import seg7_pkg::*;

  assign o_seg = seg_polarity(SEG_TABLE_H[i_hex], SEG_ACTIVE_LOW);

endmodule

// File: rtl/seg7_mux_display.sv
// Time-multiplexed N-digit seven-segment driver with frame-synchronous shadow loading,
// per-digit decimal point / blanking and optional leading-zero suppression.
module seg7_mux_display
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS       = 4,
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input logic               clk,
  input logic               rst,
  seg7_mux_display_if.slave bus
);

  localparam int unsigned IDX_W   = $clog2(N_DIGITS);
  localparam int unsigned PRESC_W = $clog2(REFRESH_DIV);
  localparam logic [6:0]  SEG_OFF = seg_polarity(SEG_OFF_H, SEG_ACTIVE_LOW);
  localparam logic [N_DIGITS-1:0] AN_OFF = {N_DIGITS{AN_ACTIVE_LOW}};

  logic [PRESC_W-1:0]    r_presc;
  logic [IDX_W-1:0]      r_idx;
  logic [4*N_DIGITS-1:0] r_pend_digits, r_shd_digits;
  logic [N_DIGITS-1:0]   r_pend_dp, r_shd_dp;
  logic [N_DIGITS-1:0]   r_pend_blank, r_shd_blank;
  logic                  r_pend_valid;
  logic                  r_frame_done;
  logic [N_DIGITS-1:0]   r_an;
  logic [6:0]            r_seg;
  logic                  r_dp;

  logic                  w_tick, w_last, w_wrap;
  logic [3:0]            w_cur_hex;
  logic                  w_cur_dp, w_cur_blank, w_upper_zero, w_dark;
  logic [N_DIGITS-1:0]   w_an_h;
  logic [6:0]            w_seg;

  assign w_tick = (r_presc == PRESC_W'(REFRESH_DIV - 1));
  assign w_last = (r_idx == IDX_W'(N_DIGITS - 1));
  assign w_wrap = w_tick && w_last;

  // Current-slot selection plus "this digit and everything left of it is zero".
  always_comb begin
    w_cur_hex    = 4'h0;
    w_cur_dp     = 1'b0;
    w_cur_blank  = 1'b0;
    w_upper_zero = 1'b1;
    w_an_h       = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_cur_hex   = r_shd_digits[4*i +: 4];
        w_cur_dp    = r_shd_dp[i];
        w_cur_blank = r_shd_blank[i];
        w_an_h[i]   = 1'b1;
      end
      if ((IDX_W'(i) >= r_idx) && (r_shd_digits[4*i +: 4] != 4'h0)) begin
        w_upper_zero = 1'b0;
      end
    end
  end

  // Digit 0 is never zero-suppressed so a zero value still shows "0".
  assign w_dark = w_cur_blank || (bus.lz_en && (r_idx != '0) && w_upper_zero);

  hex_to_7seg #(
    .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
  ) u_hex_to_7seg (
    .i_hex(w_cur_hex),
    .o_seg(w_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc       <= '0;
      r_idx         <= '0;
      r_pend_digits <= '0;
      r_pend_dp     <= '0;
      r_pend_blank  <= '0;
      r_pend_valid  <= 1'b0;
      r_shd_digits  <= '0;
      r_shd_dp      <= '0;
      r_shd_blank   <= '0;
      r_frame_done  <= 1'b0;
      r_an          <= AN_OFF;
      r_seg         <= SEG_OFF;
      r_dp          <= SEG_ACTIVE_LOW;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        r_idx <= w_last ? '0 : r_idx + 1'b1;
      end

      if (bus.load) begin
        r_pend_digits <= bus.digits;
        r_pend_dp     <= bus.dp_in;
        r_pend_blank  <= bus.blank_in;
      end

      // A load landing on the wrap cycle bypasses pending and commits directly.
      if (w_wrap) begin
        if (bus.load) begin
          r_shd_digits <= bus.digits;
          r_shd_dp     <= bus.dp_in;
          r_shd_blank  <= bus.blank_in;
        end else if (r_pend_valid) begin
          r_shd_digits <= r_pend_digits;
          r_shd_dp     <= r_pend_dp;
          r_shd_blank  <= r_pend_blank;
        end
        r_pend_valid <= 1'b0;
      end else if (bus.load) begin
        r_pend_valid <= 1'b1;
      end

      r_frame_done <= w_wrap;
      r_an         <= AN_ACTIVE_LOW ? ~w_an_h : w_an_h;
      r_seg        <= w_dark ? SEG_OFF : w_seg;
      r_dp         <= (w_cur_dp && !w_dark) ^ SEG_ACTIVE_LOW;
    end
  end

  assign bus.An         = r_an;
  assign bus.D          = r_seg;
  assign bus.Dp         = r_dp;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_mux_display.sv
// Scoreboard bench for seg7_mux_display: stimulus queues expected digit slots per frame,
// a monitor pops one entry at the start of every displayed slot.
module tb_seg7_mux_display;

  localparam logic [6:0] S0   = 7'b1000000;
  localparam logic [6:0] S3   = 7'b0110000;
  localparam logic [6:0] S5   = 7'b0010010;
  localparam logic [6:0] S8   = 7'b0000000;
  localparam logic [6:0] SA   = 7'b0001000;
  localparam logic [6:0] SF   = 7'b0001110;
  localparam logic [6:0] SOFF = 7'b1111111;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] d;
    logic       dp;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_fd = 0;
  exp_t sb_q[$];
  logic [3:0] prev_an = 'x;

  seg7_mux_display_if #(.N_DIGITS(4)) bus ();

  seg7_mux_display #(
    .N_DIGITS(4),
    .REFRESH_DIV(4),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a change of An marks a new digit slot.
  always @(negedge clk) begin
    exp_t e;
    if ((bus.An !== prev_an) && (sb_q.size() > 0)) begin
      e = sb_q.pop_front();
      check("slot_an", 32'(bus.An), 32'(e.an));
      check("slot_d", 32'(bus.D), 32'(e.d));
      check("slot_dp", 32'(bus.Dp), 32'(e.dp));
    end
    prev_an = bus.An;
  end

  task automatic push4(input logic [6:0] d0, input logic [6:0] d1, input logic [6:0] d2,
                       input logic [6:0] d3, input logic [3:0] dpn);
    sb_q.push_back('{an: 4'b1110, d: d0, dp: dpn[0]});
    sb_q.push_back('{an: 4'b1101, d: d1, dp: dpn[1]});
    sb_q.push_back('{an: 4'b1011, d: d2, dp: dpn[2]});
    sb_q.push_back('{an: 4'b0111, d: d3, dp: dpn[3]});
  endtask

  task automatic check_off(input string tag);
    check({tag, "_an"}, 32'(bus.An), 32'h0000_000F);
    check({tag, "_d"}, 32'(bus.D), 32'h0000_007F);
    check({tag, "_dp"}, 32'(bus.Dp), 32'h1);
    check({tag, "_fd"}, 32'(bus.frame_done), 32'h0);
  endtask

  task automatic mark_fd(input bit chk);
    if (chk) check("fd_period", 32'(cyc - last_fd), 32'd16);
    last_fd = cyc;
  endtask

  task automatic wait_frame(input bit chk);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_done && n < 200);
    if (!bus.frame_done) begin
      total++;
      bad++;
      $display("FAIL frame_timeout: frame_done not seen, waited %0d cycles want <= 16", n);
    end else begin
      mark_fd(chk);
    end
  endtask

  task automatic after_fd();
    @(negedge clk);
    check("fd_width", 32'(bus.frame_done), 32'h0);
  endtask

  task automatic load_pulse(input logic [15:0] dg, input logic [3:0] dp, input logic [3:0] bl);
    bus.digits   = dg;
    bus.dp_in    = dp;
    bus.blank_in = bl;
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.digits   = '0;
    bus.dp_in    = '0;
    bus.blank_in = '0;
    bus.load     = 1'b0;
    bus.lz_en    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_off("reset");

    // Frame 0: empty shadow; FA00 loaded mid-frame must not appear yet.
    push4(S0, S0, S0, S0, 4'b1111);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    load_pulse(16'hFA00, 4'b0000, 4'b0000);
    wait_frame(1'b0);

    // Frame 1: FA00, lz_en on but top digit nonzero so nothing suppressed.
    push4(S0, S0, SA, SF, 4'b1111);
    bus.lz_en = 1'b1;
    after_fd();
    load_pulse(16'h0050, 4'b0000, 4'b0000);
    wait_frame(1'b1);

    // Frame 2: 0050 with leading zeros suppressed.
    push4(S0, S5, SOFF, SOFF, 4'b1111);
    after_fd();
    load_pulse(16'h0000, 4'b0000, 4'b0000);
    wait_frame(1'b1);

    // Frame 3: all zero, only digit 0 lit; 1111, 2222 pending, 3333 on the wrap cycle.
    push4(S0, SOFF, SOFF, SOFF, 4'b1111);
    after_fd();
    load_pulse(16'h1111, 4'b0000, 4'b0000);
    repeat (3) @(negedge clk);
    load_pulse(16'h2222, 4'b0000, 4'b0000);
    repeat (9) @(negedge clk);
    bus.digits = 16'h3333;
    bus.load   = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    check("wrap_load_fd", 32'(bus.frame_done), 32'h1);
    mark_fd(1'b1);

    // Frames 4 and 5: 3333, pending must not resurface.
    push4(S3, S3, S3, S3, 4'b1111);
    after_fd();
    wait_frame(1'b1);
    push4(S3, S3, S3, S3, 4'b1111);
    after_fd();
    load_pulse(16'h8888, 4'b0100, 4'b0001);
    wait_frame(1'b1);

    // Frame 6: 8888, digit 0 blanked (An still driven), dp on digit 2.
    push4(SOFF, S8, S8, S8, 4'b1011);
    after_fd();
    load_pulse(16'h1234, 4'b0000, 4'b0000);
    repeat (12) @(negedge clk);

    // Reset across the wrap edge discards the pending 1234.
    rst = 1'b1;
    @(negedge clk);
    check_off("midrst");
    @(negedge clk);
    check_off("midrst_wrap");
    push4(S0, SOFF, SOFF, SOFF, 4'b1111);
    rst = 1'b0;
    wait_frame(1'b0);
    push4(S0, SOFF, SOFF, SOFF, 4'b1111);
    after_fd();
    wait_frame(1'b1);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_mux_display.md
Name: seg7_mux_display

Overview:
- Parametrised time-multiplexed seven-segment driver for N hex digits.
- Successor to the fixed 4-digit dynamic display in the board top level.
- Adds:
  - a programmable refresh prescaler
  - tear-free frame-synchronous loading through a shadow register
  - per-digit decimal point and blanking
  - optional leading-zero suppression
  - selectable output polarity
- Sits between the datapath (e.g. A/B operand display) and the D/An board pins.

Parameters:
- N_DIGITS, 4: number of digits; legal range 2..8.
- REFRESH_DIV, 50000: clk cycles per digit slot; must be >= 2.
- SEG_ACTIVE_LOW, 1: 1 means a segment is lit when 0.
- AN_ACTIVE_LOW, 1: 1 means an anode is enabled when 0.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- digits  in  4*N_DIGITS  hex values; digit i = digits[4i+3:4i]; digit 0 is rightmost, on An[0]
- dp_in  in  N_DIGITS  decimal point request per digit
- blank_in  in  N_DIGITS  force digit i dark
- load  in  1  single-cycle strobe; captures digits/dp_in/blank_in
- lz_en  in  1  leading-zero suppression enable (live, not shadowed)
- D  out  7  segments; D[0]=a .. D[6]=g
- Dp  out  1  decimal point segment
- An  out  N_DIGITS  anode enables, one-hot active
- frame_done  out  1  one-cycle pulse at end of each full scan

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - prescaler=0, idx=0
  - pending and shadow registers cleared to all-zero
  - pend_valid=0, frame_done=0
  - An all inactive, D all off, Dp off
  - "Off" means 1 when the corresponding ACTIVE_LOW=1, else 0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1.
  - tick=1 when count==REFRESH_DIV-1; count wraps to 0 on that same edge.
- Digit index:
  - idx, width $clog2(N_DIGITS), advances on tick.
  - Wraps from N_DIGITS-1 to 0.
  - wrap = tick && idx==N_DIGITS-1.
- Load:
  - load=1 copies the inputs into the pending register and sets pend_valid.
  - Repeated loads before a wrap overwrite pending; last value wins.
- Frame commit:
  - On wrap with pend_valid=1, shadow <= pending and pend_valid clears.
  - If load and wrap coincide, the value loaded in that cycle commits directly to shadow and pend_valid stays 0.
- Digits only change at frame boundaries; no partially updated frames are shown.
- frame_done: registered, asserted the cycle after wrap, high for exactly 1 cycle.
- Outputs are registered, one cycle after idx changes:
  - An: only bit idx active.
  - D = decode(shadow digit idx), via the 0-F hex table.
  - Dp active iff shadow dp[idx].
- Blanking: D off and Dp off, with An still active (constant duty), when either:
  - shadow blank[idx]=1, or
  - leading-zero suppressed: lz_en=1, idx!=0, and shadow digits idx..N_DIGITS-1 are all 0.
- Digit 0 is never zero-suppressed.
- Decimal point is also suppressed on blanked digits.
- Active-high hex table, g..a order:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
  - Invert all codes when SEG_ACTIVE_LOW=1.
- Reset mid-frame: takes effect on the next edge regardless of tick/load; any pending load is discarded.

Decomposition:
- Shared package seg7_pkg holds:
  - the 16-entry active-high segment table constant
  - localparam SEG_OFF_H = 7'b0000000
- Sub-module hex_to_7seg: purely combinational 4-bit to 7-bit decoder with a SEG_ACTIVE_LOW parameter; one instance.
- Prescaler, scan index, pending/shadow registers and blanking logic stay in seg7_mux_display.

Test Plan (N_DIGITS=4, REFRESH_DIV=4, both ACTIVE_LOW=1):
- Reset held 3 cycles -> An=1111, D=1111111, Dp=1, frame_done=0. After release, first commit shows shadow=0: An=1110, D=1000000.
- load with digits=16'hFA00 at t0, dp_in=0, blank_in=0 -> no change until wrap. After the commit:
  - An sequences 1110, 1101, 1011, 0111, 4 cycles each.
  - D is 1000000, 1000000, 0001000, 0001110.
  - frame_done pulses once per 16 cycles.
- lz_en=1 with digits=16'h0050 -> digit 3 D=1111111, digit 2 D=1111111, digit 1 D=0010010, digit 0 D=1000000.
- lz_en=1 with digits=16'h0000 -> only digit 0 lit, D=1000000.
- Two loads in one frame (16'h1111 then 16'h2222), then load 16'h3333 exactly on the wrap cycle -> the next frame shows 3333 (D=0110000 on every digit); 1111 and 2222 never appear.
- dp_in=4'b0100 with blank_in=4'b0001 and digits=16'h8888:
  - Digit 2 shows Dp=0.
  - Digit 0 shows D=1111111 and Dp=1 while An[0]=0.
- rst asserted mid-frame after a pending load -> outputs off next cycle, and the pending value is never displayed.
